// File: rtl/riscv_defs.sv
// Shared definitions for the register trace monitor: register indices,
// trace entry sizing and the monitor FSM state encoding.
package riscv_defs;

  localparam int unsigned NUM_REGS  = 32;
  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned REG_A0    = 10;

  // Monitor lifecycle: idle until enabled, snoop while running, frozen after halt.
  typedef enum logic [1:0] {
    MON_IDLE   = 2'd0,
    MON_RUN    = 2'd1,
    MON_HALTED = 2'd2
  } mon_state_e;

  // Width of one packed trace entry {reg index, value, timestamp}.
  function automatic int unsigned trace_entry_w(input int unsigned xlen,
                                                input int unsigned ts_w);
    return REG_IDX_W + xlen + ts_w;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO. The head entry is visible on
// dout whenever empty is low; a push into a full FIFO is accepted only when a
// pop frees a slot in the same cycle. flush empties it without touching data.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   level_q;
  logic             push_fire;
  logic             pop_fire;

  assign empty     = (level_q == '0);
  assign full      = (level_q == (PTR_W + 1)'(DEPTH));
  assign pop_fire  = pop && !empty;
  assign push_fire = push && (!full || pop_fire);
  assign dout      = mem_q[rd_ptr_q];
  assign level     = level_q;

  // Storage array: written on an accepted push.
  // NOTE: the data array is deliberately not reset; occupancy is tracked by the
  // pointers, so resetting the storage would only add a reset net to every bit.
  always_ff @(posedge clk) begin
    if (push_fire) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_fire) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_fire)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      unique case ({push_fire, pop_fire})
        2'b10:   level_q <= level_q + (PTR_W + 1)'(1);
        2'b01:   level_q <= level_q - (PTR_W + 1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/register_trace_monitor.sv
// Snoops core register-file writebacks, keeps a shadow copy and "updated" flag
// per watched register, queues each watched write with a timestamp for a
// valid/ready consumer, and latches the return register when the program halts.
module register_trace_monitor
  import riscv_defs::*;
#(
  parameter int          XLEN       = 32,
  parameter int          TS_W       = 16,
  parameter int          DEPTH      = 8,
  parameter logic [31:0] WATCH_MASK = 32'h0000_0400,
  parameter int          RET_REG    = REG_A0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [4:0]              rd_addr,
  input  logic [XLEN-1:0]         rd_value,
  input  logic                    rd_write_enable,
  input  logic                    halt,
  input  logic                    clear,
  output logic                    trace_valid,
  input  logic                    trace_ready,
  output logic [4:0]              trace_addr,
  output logic [XLEN-1:0]         trace_value,
  output logic [TS_W-1:0]         trace_ts,
  input  logic [4:0]              rdbk_addr,
  output logic [XLEN-1:0]         rdbk_value,
  output logic                    rdbk_updated,
  output logic [XLEN-1:0]         return_value,
  output logic                    return_valid,
  output logic [$clog2(DEPTH):0]  fifo_level,
  output logic [15:0]             drop_count
);

  localparam int ENTRY_W = trace_entry_w(XLEN, TS_W);

  mon_state_e        state_q;
  logic [TS_W-1:0]   ts_q;
  logic [XLEN-1:0]   shadow_q [NUM_REGS];
  logic [NUM_REGS-1:0] updated_q;
  logic [XLEN-1:0]   return_value_q;
  logic              return_valid_q;
  logic [15:0]       drop_count_q;
  logic [15:0]       drop_count_d;
  logic [XLEN-1:0]   rdbk_value_q;
  logic              rdbk_updated_q;

  logic              qualified;
  logic              fifo_push;
  logic              fifo_pop_fire;
  logic              fifo_full;
  logic              fifo_empty;
  logic              dropped;
  logic [ENTRY_W-1:0] fifo_din;
  logic [ENTRY_W-1:0] fifo_dout;
  logic [4:0]        head_addr;
  logic [XLEN-1:0]   head_value;
  logic [TS_W-1:0]   head_ts;
  logic [XLEN-1:0]   ret_src;

  // A write counts only while running, to a non-zero, watched register.
  assign qualified = (state_q == MON_RUN) && rd_write_enable &&
                     (rd_addr != '0) && WATCH_MASK[rd_addr];

  // clear flushes the queue, so a write in the same cycle is not enqueued.
  assign fifo_push     = qualified && !clear;
  assign fifo_pop_fire = trace_ready && !fifo_empty;
  assign dropped       = fifo_push && fifo_full && !fifo_pop_fire;
  assign fifo_din      = {rd_addr, rd_value, ts_q};

  // A halt that coincides with a write to the return register sees the new value.
  assign ret_src = (qualified && (rd_addr == 5'(RET_REG))) ? rd_value
                                                          : shadow_q[RET_REG];

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_trace_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (clear),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (trace_ready),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign {head_addr, head_value, head_ts} = fifo_dout;

  // Head fields are forced to zero when nothing is queued so idle outputs read 0.
  assign trace_valid = !fifo_empty;
  assign trace_addr  = fifo_empty ? '0 : head_addr;
  assign trace_value = fifo_empty ? '0 : head_value;
  assign trace_ts    = fifo_empty ? '0 : head_ts;

  // Lifecycle FSM, timestamp counter and halt-time return value capture.
  // NOTE: every register in an always_ff uses <= so all of them update from the
  // same pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= MON_IDLE;
      ts_q           <= '0;
      return_value_q <= '0;
      return_valid_q <= 1'b0;
    end else if (clear) begin
      state_q        <= MON_IDLE;
      ts_q           <= '0;
      return_valid_q <= 1'b0;
    end else begin
      if (state_q == MON_RUN) ts_q <= ts_q + TS_W'(1);
      unique case (state_q)
        MON_IDLE: begin
          if (enable) state_q <= MON_RUN;
        end
        MON_RUN: begin
          if (halt) begin
            state_q        <= MON_HALTED;
            return_value_q <= ret_src;
            return_valid_q <= 1'b1;
          end
        end
        MON_HALTED: begin
          state_q <= MON_HALTED;
        end
        default: state_q <= MON_IDLE;
      endcase
    end
  end

  // Shadow register file and per-register updated flags; clear keeps the values.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow_q[i] <= '0;
      end
      updated_q <= '0;
    end else begin
      if (qualified) shadow_q[rd_addr] <= rd_value;
      if (clear) begin
        updated_q <= '0;
      end else if (qualified) begin
        updated_q[rd_addr] <= 1'b1;
      end
    end
  end

  // Saturating count of writes lost to a full queue.
  always_comb begin
    drop_count_d = drop_count_q;
    if (dropped && (drop_count_q != 16'hFFFF)) begin
      drop_count_d = drop_count_q + 16'd1;
    end
  end

  // Drop counter register.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      drop_count_q <= '0;
    end else begin
      drop_count_q <= drop_count_d;
    end
  end

  // Registered shadow readback; x0 always reads as zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdbk_value_q   <= '0;
      rdbk_updated_q <= 1'b0;
    end else if (rdbk_addr == '0) begin
      rdbk_value_q   <= '0;
      rdbk_updated_q <= 1'b0;
    end else begin
      rdbk_value_q   <= shadow_q[rdbk_addr];
      rdbk_updated_q <= updated_q[rdbk_addr];
    end
  end

  assign rdbk_value   = rdbk_value_q;
  assign rdbk_updated = rdbk_updated_q;
  assign return_value = return_value_q;
  assign return_valid = return_valid_q;
  assign drop_count   = drop_count_q;

endmodule

// File: tb/tb_register_trace_monitor.sv
// Scoreboard bench for register_trace_monitor: a behavioural model advances on
// every rising edge and queues expected trace entries; a monitor on the falling
// edge compares the DUT's outputs and pops entries on each handshake.
module tb_register_trace_monitor;

  localparam int          XLEN  = 32;
  localparam int          TS_W  = 16;
  localparam int          DEPTH = 8;
  localparam logic [31:0] WMASK = 32'h0000_0400;

  typedef struct {
    logic [4:0]      a;
    logic [XLEN-1:0] v;
    logic [TS_W-1:0] t;
  } ent_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             enable;
  logic [4:0]       rd_addr;
  logic [XLEN-1:0]  rd_value;
  logic             rd_write_enable;
  logic             halt;
  logic             clear;
  logic             trace_valid;
  logic             trace_ready;
  logic [4:0]       trace_addr;
  logic [XLEN-1:0]  trace_value;
  logic [TS_W-1:0]  trace_ts;
  logic [4:0]       rdbk_addr;
  logic [XLEN-1:0]  rdbk_value;
  logic             rdbk_updated;
  logic [XLEN-1:0]  return_value;
  logic             return_valid;
  logic [3:0]       fifo_level;
  logic [15:0]      drop_count;

  register_trace_monitor #(
    .XLEN(XLEN), .TS_W(TS_W), .DEPTH(DEPTH), .WATCH_MASK(WMASK), .RET_REG(10)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .rd_addr(rd_addr), .rd_value(rd_value),
    .rd_write_enable(rd_write_enable), .halt(halt), .clear(clear),
    .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_addr(trace_addr),
    .trace_value(trace_value), .trace_ts(trace_ts), .rdbk_addr(rdbk_addr),
    .rdbk_value(rdbk_value), .rdbk_updated(rdbk_updated),
    .return_value(return_value), .return_valid(return_valid),
    .fifo_level(fifo_level), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  int              m_mode;       // 0 idle, 1 running, 2 halted
  int              m_ts;
  logic [XLEN-1:0] m_shadow [32];
  bit              m_upd    [32];
  logic [XLEN-1:0] m_ret;
  bit              m_rv;
  int              m_drop;
  ent_t            m_fifo[$];    // occupancy as the design sees it at each edge
  ent_t            sb_q[$];      // entries still to be observed by the monitor
  logic [XLEN-1:0] exp_rdbk_v;
  bit              exp_rdbk_u;
  logic [XLEN-1:0] popped_log[$];

  task automatic model_step();
    bit   wr_ok;
    bit   pop;
    ent_t e;
    if (rst) begin
      m_mode = 0; m_ts = 0; m_ret = '0; m_rv = 0; m_drop = 0;
      m_fifo.delete(); sb_q.delete();
      for (int i = 0; i < 32; i++) begin m_shadow[i] = '0; m_upd[i] = 0; end
      exp_rdbk_v = '0; exp_rdbk_u = 0;
      return;
    end
    exp_rdbk_v = (rdbk_addr == 0) ? '0 : m_shadow[rdbk_addr];
    exp_rdbk_u = (rdbk_addr == 0) ? 1'b0 : m_upd[rdbk_addr];
    wr_ok = (m_mode == 1) && rd_write_enable && (rd_addr != 0) && WMASK[rd_addr];
    pop   = (m_fifo.size() != 0) && trace_ready;
    if (wr_ok) m_shadow[rd_addr] = rd_value;
    if (clear) begin
      m_fifo.delete(); sb_q.delete();
      for (int i = 0; i < 32; i++) m_upd[i] = 0;
      m_rv = 0; m_drop = 0; m_ts = 0; m_mode = 0;
      return;
    end
    if (pop) void'(m_fifo.pop_front());
    if (wr_ok) begin
      m_upd[rd_addr] = 1;
      if (m_fifo.size() < DEPTH) begin
        e.a = rd_addr; e.v = rd_value; e.t = TS_W'(m_ts);
        m_fifo.push_back(e);
        sb_q.push_back(e);
      end else if (m_drop < 65535) begin
        m_drop++;
      end
    end
    if (m_mode == 1) m_ts = (m_ts + 1) % (1 << TS_W);
    if (m_mode == 0 && enable) begin
      m_mode = 1;
    end else if (m_mode == 1 && halt) begin
      m_ret  = m_shadow[10];
      m_rv   = 1;
      m_mode = 2;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // ---------------- monitor / scoreboard ----------------
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("fifo_level", 64'(fifo_level), 64'(m_fifo.size()));
      check("drop_count", 64'(drop_count), 64'(m_drop));
      check("return_value", 64'(return_value), 64'(m_ret));
      check("return_valid", 64'(return_valid), 64'(m_rv));
      check("rdbk_value", 64'(rdbk_value), 64'(exp_rdbk_v));
      check("rdbk_updated", 64'(rdbk_updated), 64'(exp_rdbk_u));
      check("trace_valid", 64'(trace_valid), 64'(sb_q.size() != 0));
      if (trace_valid && sb_q.size() != 0) begin
        check("trace_addr", 64'(trace_addr), 64'(sb_q[0].a));
        check("trace_value", 64'(trace_value), 64'(sb_q[0].v));
        check("trace_ts", 64'(trace_ts), 64'(sb_q[0].t));
        if (trace_ready) begin
          popped_log.push_back(trace_value);
          void'(sb_q.pop_front());
        end
      end else if (!trace_valid) begin
        check("trace_idle_zero", 64'({trace_addr, trace_value, trace_ts}), 64'd0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    enable = 0; rd_write_enable = 0; rd_addr = '0; rd_value = '0;
    halt = 0; clear = 0; trace_ready = 0;
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [XLEN-1:0] v);
    rd_write_enable = 1; rd_addr = a; rd_value = v;
  endtask

  task automatic drain(input string name);
    trace_ready = 1;
    for (int i = 0; i < 40 && fifo_level != 0; i++) tick();
    trace_ready = 0;
    settle();
    check(name, 64'(fifo_level), 64'd0);
    tick();
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    rdbk_addr = '0;
    rst = 1;
    tick(); tick();
    rst = 0;
    chk_en = 1;
    settle();
    check("reset_level", 64'(fifo_level), 64'd0);
    check("reset_return_valid", 64'(return_valid), 64'd0);
    check("reset_trace_valid", 64'(trace_valid), 64'd0);
    tick();

    // 1: first watched write after enable, timestamp counts RUN cycles
    enable = 1; tick(); enable = 0;
    tick(); tick(); tick();
    write_reg(5'd10, 32'hDEADBEEF); rdbk_addr = 5'd10;
    tick(); rd_write_enable = 0;
    tick(); settle();
    check("t1_level", 64'(fifo_level), 64'd1);
    check("t1_head_addr", 64'(trace_addr), 64'd10);
    check("t1_head_value", 64'(trace_value), 64'hDEADBEEF);
    check("t1_head_ts", 64'(trace_ts), 64'd3);
    check("t1_rdbk_value", 64'(rdbk_value), 64'hDEADBEEF);
    check("t1_rdbk_updated", 64'(rdbk_updated), 64'd1);
    tick();
    drain("t1_drain");

    // 2: unwatched register and x0 are ignored
    write_reg(5'd5, 32'd1); tick();
    write_reg(5'd0, 32'd7); tick();
    rd_write_enable = 0; rdbk_addr = 5'd5;
    tick(); tick(); settle();
    check("t2_rdbk_x5", 64'(rdbk_value), 64'd0);
    check("t2_rdbk_x5_upd", 64'(rdbk_updated), 64'd0);
    check("t2_level", 64'(fifo_level), 64'd0);
    check("t2_drop", 64'(drop_count), 64'd0);
    tick(); rdbk_addr = 5'd0;
    tick(); settle();
    check("t2_rdbk_x0", 64'({rdbk_updated, rdbk_value}), 64'd0);
    tick();

    // 3: overflow with consumer stalled
    for (int v = 1; v <= 10; v++) begin
      write_reg(5'd10, XLEN'(v)); tick();
    end
    rd_write_enable = 0;
    settle();
    check("t3_level", 64'(fifo_level), 64'd8);
    check("t3_drop", 64'(drop_count), 64'd2);
    tick();

    // 4: push into a full queue while popping
    popped_log.delete();
    write_reg(5'd10, 32'd9); trace_ready = 1;
    tick(); rd_write_enable = 0; trace_ready = 0;
    settle();
    check("t4_level", 64'(fifo_level), 64'd8);
    check("t4_drop", 64'(drop_count), 64'd2);
    tick();
    drain("t4_drain");
    check("t4_pop_count", 64'(popped_log.size()), 64'd9);
    for (int i = 0; i < popped_log.size() && i < 9; i++) begin
      check("t4_pop_order", 64'(popped_log[i]), 64'(i + 1));
    end

    // 5: halt with a bypassed write to a0, then a write that must be ignored
    write_reg(5'd10, 32'd42); halt = 1;
    tick(); halt = 0;
    write_reg(5'd10, 32'd5);
    tick(); rd_write_enable = 0; rdbk_addr = 5'd10;
    tick(); tick(); settle();
    check("t5_return_value", 64'(return_value), 64'd42);
    check("t5_return_valid", 64'(return_valid), 64'd1);
    check("t5_rdbk_a0", 64'(rdbk_value), 64'd42);
    check("t5_level", 64'(fifo_level), 64'd1);
    tick();

    // 6: clear, then restart with the timestamp back at zero
    clear = 1; tick(); clear = 0;
    settle();
    check("t6_return_valid", 64'(return_valid), 64'd0);
    check("t6_level", 64'(fifo_level), 64'd0);
    check("t6_return_value", 64'(return_value), 64'd42);
    tick();
    enable = 1; tick(); enable = 0;
    write_reg(5'd10, 32'd77); tick(); rd_write_enable = 0;
    settle();
    check("t6_restart_ts", 64'(trace_ts), 64'd0);
    check("t6_restart_value", 64'(trace_value), 64'd77);
    tick();

    // random traffic, checked entirely by the model and scoreboard
    for (int c = 0; c < 3000; c++) begin
      enable          = ($urandom_range(0, 9) == 0);
      rd_write_enable = ($urandom_range(0, 9) < 6);
      rd_addr         = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'd10;
      rd_value        = $urandom;
      halt            = ($urandom_range(0, 39) == 0);
      clear           = ($urandom_range(0, 79) == 0);
      trace_ready     = ($urandom_range(0, 1) == 1);
      rdbk_addr       = ($urandom_range(0, 1) == 1) ? 5'd10 : 5'($urandom_range(0, 31));
      tick();
    end
    idle_inputs();
    drain("final_drain");
    check("final_sb_empty", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
